// File: rtl/multicycle_mips.sv
// Multi-cycle MIPS subset core (add/sub/and/or/slt, lw, sw, beq, j, jal, jr).
// A 5-state FSM shares one ALU; instruction and data memories may stall it through ready handshakes.
module multicycle_mips #(
  parameter int          ADDR_W   = 7,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          NREG     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [31:0]       IR_addr,
  input  logic [31:0]       IR,
  input  logic              IR_valid,
  input  logic [31:0]       ReadDataMem,
  input  logic              mem_ready,
  output logic              CEN,
  output logic              WEN,
  output logic              OEN,
  output logic [ADDR_W-1:0] A,
  output logic [31:0]       WriteDataMem,
  output logic [31:0]       RF_writedata,
  output logic              wb_valid
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2a;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;

  state_t      state;
  logic [31:0] pc, npc, instr, reg_a, reg_b, imm, aluout, mdr;
  logic [31:0] rf [NREG];
  logic [31:0] alu_b, alu_y;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, dest;
  logic        unused_shamt;

  assign op           = instr[31:26];
  assign rs           = instr[25:21];
  assign rt           = instr[20:16];
  assign rd           = instr[15:11];
  assign funct        = instr[5:0];
  assign unused_shamt = ^instr[10:6];
  assign dest         = (op == OP_RTYPE) ? rd : rt;

  assign IR_addr = pc;
  assign OEN     = 1'b0;

  // Shared ALU: address add for lw/sw, compare-subtract for beq, funct-selected op for R-type.
  always_comb begin
    alu_b = (op == OP_LW || op == OP_SW) ? imm : reg_b;
    alu_y = reg_a + alu_b;
    if (op == OP_BEQ) begin
      alu_y = reg_a - alu_b;
    end else if (op == OP_RTYPE) begin
      case (funct)
        FN_SUB:  alu_y = reg_a - alu_b;
        FN_AND:  alu_y = reg_a & alu_b;
        FN_OR:   alu_y = reg_a | alu_b;
        FN_SLT:  alu_y = {31'b0, $signed(reg_a) < $signed(alu_b)};
        default: alu_y = reg_a + alu_b;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= FETCH;
      pc           <= RESET_PC;
      npc          <= '0;
      instr        <= '0;
      reg_a        <= '0;
      reg_b        <= '0;
      imm          <= '0;
      aluout       <= '0;
      mdr          <= '0;
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
      CEN          <= 1'b1;
      WEN          <= 1'b1;
      A            <= '0;
      WriteDataMem <= '0;
      RF_writedata <= '0;
      wb_valid     <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      case (state)
        FETCH: begin
          if (IR_valid) begin
            instr <= IR;
            npc   <= pc + 32'd4;
            state <= DECODE;
          end
        end
        DECODE: begin
          reg_a <= rf[rs];
          reg_b <= rf[rt];
          imm   <= {{16{instr[15]}}, instr[15:0]};
          state <= EXEC;
          // Jumps and unknown opcodes retire here; the rest go on to the ALU.
          case (op)
            OP_J: begin
              pc    <= {npc[31:28], instr[25:0], 2'b00};
              state <= FETCH;
            end
            OP_JAL: begin
              pc           <= {npc[31:28], instr[25:0], 2'b00};
              rf[31]       <= npc;
              RF_writedata <= npc;
              wb_valid     <= 1'b1;
              state        <= FETCH;
            end
            OP_RTYPE: begin
              if (funct == FN_JR) begin
                pc    <= rf[rs];
                state <= FETCH;
              end
            end
            OP_BEQ, OP_LW, OP_SW: ;
            default: begin
              pc    <= npc;
              state <= FETCH;
            end
          endcase
        end
        EXEC: begin
          aluout <= alu_y;
          case (op)
            OP_BEQ: begin
              pc    <= (alu_y == 32'd0) ? npc + {imm[29:0], 2'b00} : npc;
              state <= FETCH;
            end
            OP_LW, OP_SW: begin
              CEN          <= 1'b0;
              WEN          <= (op != OP_SW);
              A            <= alu_y[ADDR_W+1:2];
              WriteDataMem <= reg_b;
              state        <= MEM;
            end
            default: state <= WB;
          endcase
        end
        MEM: begin
          if (mem_ready) begin
            CEN <= 1'b1;
            WEN <= 1'b1;
            if (op == OP_SW) begin
              pc    <= npc;
              state <= FETCH;
            end else begin
              mdr   <= ReadDataMem;
              state <= WB;
            end
          end
        end
        WB: begin
          if (dest != 5'd0) rf[dest] <= (op == OP_LW) ? mdr : aluout;
          RF_writedata <= (op == OP_LW) ? mdr : aluout;
          wb_valid     <= 1'b1;
          pc           <= npc;
          state        <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_mips.sv
// Bench for multicycle_mips: directed scenarios followed by random instructions,
// each checked against an instruction-level model of the ISA with stall-aware latencies.
module tb_multicycle_mips;

  localparam int          AW     = 7;
  localparam logic [31:0] RST_PC = 32'h0;

  logic          clk, rst_n;
  logic [31:0]   IR_addr, IR, ReadDataMem, WriteDataMem, RF_writedata;
  logic          IR_valid, mem_ready, CEN, WEN, OEN, wb_valid;
  logic [AW-1:0] A;

  multicycle_mips #(.ADDR_W(AW), .RESET_PC(RST_PC), .NREG(32)) dut (
    .clk(clk), .rst_n(rst_n), .IR_addr(IR_addr), .IR(IR), .IR_valid(IR_valid),
    .ReadDataMem(ReadDataMem), .mem_ready(mem_ready), .CEN(CEN), .WEN(WEN), .OEN(OEN),
    .A(A), .WriteDataMem(WriteDataMem), .RF_writedata(RF_writedata), .wb_valid(wb_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [31:0] cur_instr;
  logic        ir_en;
  int          mem_delay;
  assign IR       = cur_instr;
  assign IR_valid = ir_en;

  logic [31:0] dmem [0:127];
  bit          mem_inited;
  int          cen_low_cnt;
  int          wr_count;

  function automatic logic [31:0] init_word(input int i);
    case (i)
      0:       return 32'd5;
      1:       return 32'd7;
      2:       return 32'hDEADBEEF;
      default: return (i * 32'h9E3779B1) ^ 32'h5A5A1234;
    endcase
  endfunction

  // Slow data memory: ready after mem_delay cycles of CEN low, writes on the ready edge.
  assign ReadDataMem = dmem[A];
  assign mem_ready   = !CEN && (cen_low_cnt >= mem_delay);
  always @(posedge clk) begin
    if (!mem_inited) begin
      for (int i = 0; i < 128; i++) dmem[i] <= init_word(i);
      mem_inited <= 1'b1;
    end else if (!CEN) begin
      cen_low_cnt <= cen_low_cnt + 1;
      if (!WEN && mem_ready) begin
        dmem[A]  <= WriteDataMem;
        wr_count <= wr_count + 1;
      end
    end else begin
      cen_low_cnt <= 0;
    end
  end

  int total, bad;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Architectural reference state.
  logic [31:0]   m_regs [32];
  logic [31:0]   ref_mem [128];
  logic [31:0]   m_pc;
  logic [31:0]   e_pc, e_data, e_sdata;
  int            e_lat, e_cen, e_wkind;
  logic [AW-1:0] e_a;
  logic          e_wen, e_store;

  task automatic model_write(input logic [4:0] dst, input logic [31:0] val);
    e_data  = val;
    e_wkind = (dst != 5'd0) ? 1 : 2;
    if (dst != 5'd0) m_regs[dst] = val;
  endtask

  task automatic model_step(input logic [31:0] ins, input int md);
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd;
    logic [31:0] a, b, se, pc4, addr, r;
    op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11]; fn = ins[5:0];
    a = m_regs[rs]; b = m_regs[rt];
    se = {{16{ins[15]}}, ins[15:0]};
    pc4 = m_pc + 32'd4;
    addr = a + se;
    e_pc = pc4; e_lat = 2; e_wkind = 0; e_data = '0; e_cen = 0;
    e_a = addr[AW+1:2]; e_wen = 1'b1; e_store = 1'b0; e_sdata = b;
    case (op)
      6'h00: begin
        if (fn == 6'h08) begin
          e_pc = a;
        end else begin
          case (fn)
            6'h22:   r = a - b;
            6'h24:   r = a & b;
            6'h25:   r = a | b;
            6'h2a:   r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: r = a + b;
          endcase
          e_lat = 4;
          model_write(rd, r);
        end
      end
      6'h23: begin
        e_lat = 5 + md; e_cen = md + 1;
        model_write(rt, ref_mem[e_a]);
      end
      6'h2b: begin
        e_lat = 4 + md; e_cen = md + 1; e_wen = 1'b0; e_store = 1'b1;
        ref_mem[e_a] = b;
      end
      6'h04: begin
        e_lat = 3;
        if (a == b) e_pc = pc4 + (se << 2);
      end
      6'h02: e_pc = {pc4[31:28], ins[25:0], 2'b00};
      6'h03: begin
        e_pc = {pc4[31:28], ins[25:0], 2'b00};
        model_write(5'd31, pc4);
      end
      default: ;
    endcase
    m_pc = e_pc;
  endtask

  // Runs one instruction from FETCH (at a negedge) until it retires, checking every cycle.
  task automatic apply_stimulus(input logic [31:0] ins, input int ir_delay, input int md);
    logic [31:0] old_pc;
    int          cen_seen;
    old_pc = m_pc;
    check_output("pc_at_fetch", IR_addr, old_pc);
    mem_delay = md; cur_instr = ins; ir_en = 1'b0;
    for (int s = 0; s < ir_delay; s++) begin
      @(negedge clk);
      check_output("stall_pc", IR_addr, old_pc);
      check_output("stall_wb", wb_valid, 1'b0);
      check_output("stall_cen", CEN, 1'b1);
    end
    ir_en = 1'b1;
    model_step(ins, md);
    cen_seen = 0;
    for (int c = 1; c <= e_lat; c++) begin
      @(negedge clk);
      ir_en = 1'b0;
      if (CEN === 1'b0) begin
        cen_seen++;
        check_output("mem_a", A, e_a);
        check_output("mem_wen", WEN, e_wen);
        if (e_store) check_output("mem_wdata", WriteDataMem, e_sdata);
      end
      if (c < e_lat) begin
        check_output("pc_hold", IR_addr, old_pc);
        check_output("wb_quiet", wb_valid, 1'b0);
      end
    end
    check_output("next_pc", IR_addr, e_pc);
    check_output("cen_cycles", cen_seen, e_cen);
    if (e_wkind == 1) begin
      check_output("wb_valid", wb_valid, 1'b1);
      check_output("wb_data", RF_writedata, e_data);
    end else if (e_wkind == 0) begin
      check_output("wb_none", wb_valid, 1'b0);
    end
    if (e_store) check_output("dmem_store", dmem[e_a], ref_mem[e_a]);
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tgt);
    return {op, tgt};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0] rs, rt, rd;
    logic [5:0] fn, op;
    rs = 5'($urandom_range(0, 7));
    rt = 5'($urandom_range(0, 7));
    rd = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 5))
      0:       fn = 6'h20;
      1:       fn = 6'h22;
      2:       fn = 6'h24;
      3:       fn = 6'h25;
      4:       fn = 6'h2a;
      default: fn = 6'h27;
    endcase
    case ($urandom_range(0, 2))
      0:       op = 6'h08;
      1:       op = 6'h0f;
      default: op = 6'h3f;
    endcase
    case ($urandom_range(0, 11))
      0, 1, 2, 3: return enc_r(rs, rt, rd, fn);
      4, 5:       return enc_i(6'h23, rs, 5'($urandom_range(1, 7)), 16'($urandom));
      6:          return enc_i(6'h2b, rs, rt, 16'($urandom));
      7:          return enc_i(6'h04, rs, ($urandom_range(0, 1) == 0) ? rs : rt,
                               16'($urandom_range(0, 15)) - 16'd8);
      8:          return enc_j(6'h02, 26'($urandom));
      9:          return enc_j(6'h03, 26'($urandom));
      10:         return enc_r(rs, 5'd0, 5'd0, 6'h08);
      default:    return enc_i(op, rs, rt, 16'($urandom));
    endcase
  endfunction

  initial begin
    int wr_before;
    total = 0; bad = 0;
    rst_n = 1'b0; ir_en = 1'b0; cur_instr = '0; mem_delay = 0;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    for (int i = 0; i < 128; i++) ref_mem[i] = init_word(i);
    m_pc = RST_PC;

    @(negedge clk);
    check_output("rst_cen", CEN, 1'b1);
    check_output("rst_wen", WEN, 1'b1);
    check_output("rst_oen", OEN, 1'b0);
    check_output("rst_a", A, '0);
    check_output("rst_wdata", WriteDataMem, '0);
    check_output("rst_rfwd", RF_writedata, '0);
    check_output("rst_wbv", wb_valid, 1'b0);
    check_output("rst_pc", IR_addr, RST_PC);
    rst_n = 1'b1;

    $display("[TB] reset during sw MEM");
    cur_instr = enc_i(6'h2b, 5'd0, 5'd0, 16'd0);
    mem_delay = 50; ir_en = 1'b1;
    @(negedge clk); ir_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_output("t1_in_mem", CEN, 1'b0);
    wr_before = wr_count;
    rst_n = 1'b0;
    #1;
    check_output("t1_cen", CEN, 1'b1);
    check_output("t1_wen", WEN, 1'b1);
    check_output("t1_pc", IR_addr, RST_PC);
    @(negedge clk);
    rst_n = 1'b1; mem_delay = 0;
    @(negedge clk);
    check_output("t1_no_write", wr_count, wr_before);
    m_pc = RST_PC;

    $display("[TB] lw preload and R chain");
    apply_stimulus(enc_i(6'h23, 5'd0, 5'd1, 16'd0), 0, 0);
    apply_stimulus(enc_i(6'h23, 5'd0, 5'd2, 16'd4), 0, 0);
    apply_stimulus(enc_r(5'd1, 5'd2, 5'd3, 6'h20), 0, 0);
    check_output("t2_add", RF_writedata, 32'd12);

    $display("[TB] slow lw");
    apply_stimulus(enc_i(6'h23, 5'd0, 5'd4, 16'd8), 0, 3);
    check_output("t3_lw", RF_writedata, 32'hDEADBEEF);

    $display("[TB] beq");
    apply_stimulus(enc_j(6'h02, 26'h4), 0, 0);
    apply_stimulus(enc_i(6'h04, 5'd1, 5'd1, 16'hFFFF), 0, 0);
    check_output("t4_taken", IR_addr, 32'h10);
    apply_stimulus(enc_i(6'h04, 5'd1, 5'd2, 16'hFFFF), 0, 0);
    check_output("t4_not_taken", IR_addr, 32'h14);

    $display("[TB] jal / jr");
    apply_stimulus(enc_j(6'h02, 26'h8), 0, 0);
    apply_stimulus(enc_j(6'h03, 26'h40), 0, 0);
    check_output("t5_link", RF_writedata, 32'h24);
    check_output("t5_jal_pc", IR_addr, 32'h100);
    apply_stimulus(enc_r(5'd31, 5'd0, 5'd0, 6'h08), 0, 0);
    check_output("t5_jr_pc", IR_addr, 32'h24);

    $display("[TB] fetch stall and $0");
    apply_stimulus(enc_r(5'd1, 5'd2, 5'd0, 6'h20), 5, 0);
    apply_stimulus(enc_i(6'h2b, 5'd0, 5'd0, 16'd12), 0, 0);
    check_output("t6_zero", dmem[3], 32'd0);

    $display("[TB] random instructions");
    for (int k = 0; k < 200; k++) begin
      apply_stimulus(rand_instr(), $urandom_range(0, 2), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
